// File: rtl/unary_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : unary_stream_decoder
//  Purpose  : Decodes a temporal-unary bit stream, framed by in_last, into a
//             binary magnitude. Frames longer than 2^SIZE beats are closed
//             early with out_err set, and their tail is dropped.
//  Config   : UNARY_DEC_BIPOLAR_EN defined   -> out = ones - zeros
//                                               (two's complement)
//             UNARY_DEC_BIPOLAR_EN undefined -> out = ones count
//  Revision : 1.0  initial release
// ============================================================================
module unary_stream_decoder #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  logic            u_bit,
    input  logic            in_last,
    output logic            in_ready,
    output logic [SIZE+1:0] out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Longest frame that is still counted; reaching it without in_last
    // closes the frame with an overflow result.
    localparam logic [SIZE:0] c_max_beats = {1'b1, {SIZE{1'b0}}};

    state_t          state_q, state_d;
    logic [SIZE:0]   ones_q, ones_d;
    logic [SIZE:0]   beats_q, beats_d;
    logic [SIZE+1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            out_err_q, out_err_d;

    logic            w_accept;
    logic [SIZE:0]   w_ones_nxt;
    logic [SIZE:0]   w_beats_nxt;
    logic            w_full;
    logic [SIZE+1:0] w_result;

    // While discarding, no result is produced, so the tail is never stalled.
    assign in_ready = (state_q == DISCARD) | ~out_valid_q | out_ready;
    assign w_accept = in_valid & in_ready;

    // Counts including the beat currently being accepted, so the closing
    // beat is part of the result.
    assign w_ones_nxt  = ones_q + {{SIZE{1'b0}}, u_bit};
    assign w_beats_nxt = beats_q + {{SIZE{1'b0}}, 1'b1};
    assign w_full      = (w_beats_nxt == c_max_beats);

`ifdef UNARY_DEC_BIPOLAR_EN
    // ones - zeros = 2*ones - beats; both operands fit SIZE+2 bits.
    assign w_result = {w_ones_nxt, 1'b0} - {1'b0, w_beats_nxt};
`else
    assign w_result = {1'b0, w_ones_nxt};
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

    // State, counters and result register; async reset drops any open frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ones_q      <= '0;
            beats_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            beats_q     <= beats_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    // Next state, counter update and result load/delivery.
    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        beats_d     = beats_q;
        out_d       = out_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        // Delivery clears valid; a load below in the same cycle overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    if (in_last) begin
                        out_d       = w_result;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        ones_d      = '0;
                        beats_d     = '0;
                        state_d     = IDLE;
                    end else if (w_full) begin
                        out_d       = w_result;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        ones_d      = '0;
                        beats_d     = '0;
                        state_d     = DISCARD;
                    end else begin
                        ones_d      = w_ones_nxt;
                        beats_d     = w_beats_nxt;
                        state_d     = ACCUM;
                    end
                end
            end
            DISCARD: begin
                if (w_accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
